// File: rtl/multiport_regfile.sv
// Two-write / two-read register file with registered, zero-gated reads and a saturating write-collision counter.
// Define REGFILE_BYPASS_EN to forward same-edge write data to reads of the same address.
module multiport_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             wr2_en,
  input  logic [AW-1:0]    wr2_addr,
  input  logic [WIDTH-1:0] wr2_data,
  input  logic             rdA_en,
  input  logic [AW-1:0]    rdA_addr,
  input  logic             rdB_en,
  input  logic [AW-1:0]    rdB_addr,
  output logic [WIDTH-1:0] rdA_data,
  output logic [WIDTH-1:0] rdB_data,
  output logic             rdA_valid,
  output logic             rdB_valid,
  input  logic             conflict_clr,
  output logic [7:0]       conflict_cnt
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr1_ok;
  logic             wr2_ok;
  logic             collide;
  logic [WIDTH-1:0] rd_a_word;
  logic [WIDTH-1:0] rd_b_word;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  // Out-of-range writes are dropped entirely, so they can never collide.
  always_comb begin
    wr1_ok  = wr1_en && in_range(wr1_addr);
    wr2_ok  = wr2_en && in_range(wr2_addr);
    collide = wr1_ok && wr2_ok && (wr1_addr == wr2_addr);
  end

  // Read word selection; the bypass build lets the winning same-edge write override storage.
  always_comb begin
    rd_a_word = '0;
    rd_b_word = '0;
    if (in_range(rdA_addr)) rd_a_word = mem[rdA_addr];
    if (in_range(rdB_addr)) rd_b_word = mem[rdB_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr2_ok && (wr2_addr == rdA_addr)) rd_a_word = wr2_data;
    if (wr1_ok && (wr1_addr == rdA_addr)) rd_a_word = wr1_data;
    if (wr2_ok && (wr2_addr == rdB_addr)) rd_b_word = wr2_data;
    if (wr1_ok && (wr1_addr == rdB_addr)) rd_b_word = wr1_data;
`endif
  end

  // Storage: port 1 wins when both ports target the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr1_ok && (wr1_addr == AW'(i)))      mem[i] <= wr1_data;
        else if (wr2_ok && (wr2_addr == AW'(i))) mem[i] <= wr2_data;
      end
    end
  end

  // Registered read ports; data is forced to zero whenever no request was sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdA_data  <= '0;
      rdB_data  <= '0;
      rdA_valid <= 1'b0;
      rdB_valid <= 1'b0;
    end else begin
      rdA_valid <= rdA_en;
      rdB_valid <= rdB_en;
      rdA_data  <= rdA_en ? rd_a_word : '0;
      rdB_data  <= rdB_en ? rd_b_word : '0;
    end
  end

  // Collision counter; clear beats a same-edge increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (conflict_clr) begin
      conflict_cnt <= '0;
    end else if (collide && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter WIDTH, default 16, data width of every entry in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH), address width; SHALL NOT be overridden.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr1_en  input  1  write port 1 enable, highest priority.
REQ-007 wr1_addr  input  AW  write port 1 address.
REQ-008 wr1_data  input  WIDTH  write port 1 data.
REQ-009 wr2_en  input  1  write port 2 enable.
REQ-010 wr2_addr  input  AW  write port 2 address.
REQ-011 wr2_data  input  WIDTH  write port 2 data.
REQ-012 rdA_en, rdB_en  input  1 each  read request, ports A and B.
REQ-013 rdA_addr, rdB_addr  input  AW each  read addresses.
REQ-014 rdA_data, rdB_data  output  WIDTH each  registered read data.
REQ-015 rdA_valid, rdB_valid  output  1 each  one-cycle pulse qualifying read data.
REQ-016 conflict_clr  input  1  synchronous clear of conflict_cnt.
REQ-017 conflict_cnt  output  8  saturating count of same-address write collisions.

Function
REQ-018 Write: on a clk edge with wrN_en=1 and wrN_addr<DEPTH, entry wrN_addr SHALL take wrN_data.
REQ-019 Both writes enabled, different addresses: both entries SHALL be written on the same edge.
REQ-020 Both writes enabled, same address: only wr1_data SHALL be written and conflict_cnt SHALL increment by 1.
REQ-021 conflict_cnt SHALL saturate at 255 and stay there until reset or conflict_clr.
REQ-022 conflict_clr=1 SHALL load 0 on that edge, taking precedence over a same-cycle increment.
REQ-023 Write with address >= DEPTH SHALL be ignored; it SHALL NOT count as a conflict.
REQ-024 Read latency: request sampled at edge N; rdX_data and rdX_valid=1 SHALL be presented after edge N, held for exactly one cycle.
REQ-025 Cycle with rdX_en=0: after the edge rdX_valid SHALL be 0 and rdX_data SHALL be 0 (zero-gated, never stale).
REQ-026 Read of address >= DEPTH SHALL return 0 with rdX_valid=1.
REQ-027 Ports A and B SHALL be independent; both may read the same address in the same cycle.
REQ-028 Back-to-back reads every cycle SHALL be supported at full throughput, no stall.

Reset
REQ-029 reset=1 SHALL immediately clear every entry, rdA_data, rdB_data, rdA_valid, rdB_valid and conflict_cnt to 0, independent of clk.
REQ-030 Writes and reads issued in a cycle where reset is asserted SHALL be discarded; first effective edge is the first one after reset deasserts.
REQ-031 Reset asserted mid-stream SHALL drop any pending valid pulse with no partial update.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN selects write-to-read forwarding.
REQ-033 Defined: a read sampled on the same edge as an effective write to the same address SHALL return the winning written data (wr1 over wr2).
REQ-034 Undefined: such a read SHALL return the entry contents prior to that edge's write.
REQ-035 Both builds SHALL be identical in all other behaviour and port list.

Verification
REQ-036 Reset, then wr1 addr3=0xBEEF; next cycle rdA addr3 -> rdA_data=0xBEEF, rdA_valid=1 for one cycle.
REQ-037 wr1 addr5=0x1111 and wr2 addr5=0x2222 same cycle -> entry5=0x1111, conflict_cnt=1; wr2 addr6=0x2222 alongside -> entry6 written, count unchanged.
REQ-038 Entry2=0xAAAA; wr1 addr2=0x5555 with rdB addr2 same cycle -> rdB_data=0x5555 with REGFILE_BYPASS_EN, 0xAAAA without.
REQ-039 260 consecutive conflicting write pairs -> conflict_cnt=255; conflict_clr with another conflict -> 0.
REQ-040 DEPTH=6: wr1 addr7=0xFFFF then rdA addr7 -> rdA_data=0, valid=1; entries 0..5 unchanged.
REQ-041 Fill all entries, assert reset between clk edges -> all outputs 0 immediately; read addr0 after release -> 0.
